// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Initiator-side controller for the single-port synchronous `sram` block.
// Takes single-word writes and burst reads over a valid/ready request channel.
// Drives registered address, write-data and write-enable into the memory,
// allowing for its one-cycle registered read latency. Read words and write
// acknowledgements go out on a valid/ready response channel.
//
// Optional feature: define SRAM_CTRL_BOUND_CHK_EN to reject requests whose
// last word lies at or beyond WORD_DEPTH. Such a request gets a single error
// beat and never touches the memory. Without the macro, rsp_err is always 0
// and burst addresses wrap modulo 2^ADDR_WIDTH.
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_DEPTH = 4096,
    parameter int WORD_WIDTH = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    // memory side
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] beat_cnt;   // beats still to fetch after the current one
    logic                 req_oob;    // request's last word is outside the implemented depth

    // The implemented depth cannot exceed the address space.
    if (WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("sram_ctrl: WORD_DEPTH exceeds 2**ADDR_WIDTH");
    end

`ifdef SRAM_CTRL_BOUND_CHK_EN
    // Compute the burst end one bit wider than the address, so that a burst
    // running past the top of the address space counts as out of range rather
    // than wrapping back to a low address.
    logic [ADDR_WIDTH:0] req_end;

    assign req_end = {1'b0, req_addr}
                   + (req_we ? '0 : (ADDR_WIDTH+1)'(req_len));
    assign req_oob = (req_end >= (ADDR_WIDTH+1)'(WORD_DEPTH));
`else
    assign req_oob = 1'b0;
`endif

    // Requests are accepted only while nothing is in flight.
    assign req_ready = (state == IDLE);

    // Transaction sequencer; every memory-side and response output is a flop.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_oob) begin
                            // Rejected: answer with one error beat and leave memory alone.
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_last  <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end else begin
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                            mem_we    <= req_we;
                            beat_cnt  <= req_we ? '0 : req_len;
                            state     <= req_we ? WR : RD_ADDR;
                        end
                    end
                end

                WR: begin
                    // The memory commits the word on this edge; acknowledge it.
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_last  <= 1'b1;
                    state     <= RESP;
                end

                RD_ADDR: begin
                    // The memory registers mem[mem_addr] on this edge.
                    mem_we <= 1'b0;
                    state  <= RD_DATA;
                end

                RD_DATA: begin
                    rsp_data  <= mem_rdata;
                    rsp_valid <= 1'b1;
                    rsp_last  <= (beat_cnt == '0);
                    state     <= RESP;
                end

                RESP: begin
                    // Hold the beat until the consumer takes it.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        if (rsp_last) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                            mem_addr <= mem_addr + 1'b1;   // wraps modulo 2^ADDR_WIDTH
                            state    <= RD_ADDR;
                        end
                    end
                end

                // NOTE: an explicit default keeps the case full; unreachable encodings recover to IDLE.
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Scoreboard bench for sram_ctrl. It includes a behavioural model of the
// single-port sram with a registered read. Stimulus pushes hand-computed
// response beats into a queue. A negedge monitor pops and compares one entry
// for every response handshake. Build with SRAM_CTRL_BOUND_CHK_EN defined to
// exercise the bounds check against a 4000-word memory.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int AW = 12;
    localparam int WW = 16;
    localparam int LW = 4;
`ifdef SRAM_CTRL_BOUND_CHK_EN
    localparam int DEPTH = 4000;
`else
    localparam int DEPTH = 4096;
`endif

    typedef struct packed {
        logic [WW-1:0] data;
        logic          last;
        logic          err;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [WW-1:0] req_wdata;
    logic [LW-1:0] req_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [WW-1:0] rsp_data;
    logic          rsp_last;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          mem_we;
    logic [WW-1:0] mem_rdata;

    logic [WW-1:0] mem [0:(1<<AW)-1];

    exp_t          exp_q[$];
    int            hs_edges[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            accept_cyc = 0;
    int            we_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    logic [WW-1:0] we_data = '0;

    sram_ctrl #(
        .ADDR_WIDTH (AW),
        .WORD_DEPTH (DEPTH),
        .WORD_WIDTH (WW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sram: synchronous write, one-cycle registered read.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: records write strobes and scores every response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            if (rsp_valid && rsp_ready) begin
                hs_edges.push_back(cyc + 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data 0x%0h expected no beat", rsp_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_last", 32'(rsp_last), 32'(e.last));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic expect_beat(input logic [WW-1:0] d, input logic l, input logic e);
        exp_q.push_back('{data: d, last: l, err: e});
    endtask

    task automatic send(input logic we, input logic [AW-1:0] addr,
                        input logic [WW-1:0] wd, input logic [LW-1:0] len);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) fail_now("req_ready_wait");
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_len   = len;
        @(posedge clk); #1;
        accept_cyc = cyc;
        req_valid  = 1'b0;
        req_we     = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || !req_ready) fail_now("wait_done");
    endtask

    task automatic write_word(input logic [AW-1:0] addr, input logic [WW-1:0] d);
        expect_beat('0, 1'b1, 1'b0);
        send(1'b1, addr, d, '0);
        wait_done();
    endtask

    // Absolute guard so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            we0;
        logic [WW-1:0] held_d;
        logic [AW-1:0] held_a;
        int            n;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_len   = '0;
        rsp_ready = 1'b1;
        #3;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write, then read it back.
        we0 = we_cnt;
        write_word(12'h010, 16'hBEEF);
        check("wr_we_cycles", 32'(we_cnt - we0), 32'd1);
        check("wr_mem_addr", 32'(we_addr), 32'h010);
        check("wr_mem_wdata", 32'(we_data), 32'hBEEF);
        we0 = we_cnt;
        expect_beat(16'hBEEF, 1'b1, 1'b0);
        send(1'b0, 12'h010, '0, '0);
        wait_done();
        check("rd_no_we", 32'(we_cnt - we0), 32'd0);

        // Four-beat burst with no backpressure.
        for (int i = 0; i < 4; i++) write_word(12'h100 + 12'(i), 16'h1111 * 16'(i + 1));
        expect_beat(16'h1111, 1'b0, 1'b0);
        expect_beat(16'h2222, 1'b0, 1'b0);
        expect_beat(16'h3333, 1'b0, 1'b0);
        expect_beat(16'h4444, 1'b1, 1'b0);
        we0 = we_cnt;
        hs_edges.delete();
        send(1'b0, 12'h100, '0, 4'd3);
        wait_done();
        check("burst_beats", 32'(hs_edges.size()), 32'd4);
        if (hs_edges.size() >= 4) begin
            check("burst_first_latency", 32'(hs_edges[0] - accept_cyc), 32'd3);
            check("burst_cadence", 32'(hs_edges[3] - hs_edges[0]), 32'd9);
        end
        check("burst_no_we", 32'(we_cnt - we0), 32'd0);

        // Same burst, consumer stalls 5 cycles on beat 2.
        expect_beat(16'h1111, 1'b0, 1'b0);
        expect_beat(16'h2222, 1'b0, 1'b0);
        expect_beat(16'h3333, 1'b0, 1'b0);
        expect_beat(16'h4444, 1'b1, 1'b0);
        hs_edges.delete();
        send(1'b0, 12'h100, '0, 4'd3);
        n = 0;
        while (hs_edges.size() < 1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (hs_edges.size() < 1) fail_now("stall_first_beat");
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid) fail_now("stall_beat2_valid");
        held_d = rsp_data;
        held_a = mem_addr;
        check("stall_beat2_data", 32'(held_d), 32'h2222);
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_valid_held", 32'(rsp_valid), 32'd1);
            check("stall_data_held", 32'(rsp_data), 32'(held_d));
            check("stall_addr_held", 32'(mem_addr), 32'(held_a));
        end
        rsp_ready = 1'b1;
        wait_done();

`ifdef SRAM_CTRL_BOUND_CHK_EN
        // Out-of-range burst: single error beat, no memory access.
        expect_beat('0, 1'b1, 1'b1);
        we0 = we_cnt;
        hs_edges.delete();
        send(1'b0, 12'hF9E, '0, 4'd2);
        wait_done();
        if (hs_edges.size() >= 1)
            check("err_latency", 32'(hs_edges[0] - accept_cyc), 32'd1);
        else
            fail_now("err_beat_missing");
        check("err_no_we", 32'(we_cnt - we0), 32'd0);
        // Out-of-range write must leave memory untouched.
        expect_beat('0, 1'b1, 1'b1);
        send(1'b1, 12'hFA0, 16'h5A5A, '0);
        wait_done();
        check("err_wr_no_we", 32'(we_cnt - we0), 32'd0);
        check("err_wr_mem", 32'(mem[12'hFA0]), 32'd0);
        // Burst ending exactly on the last word is legal.
        expect_beat('0, 1'b0, 1'b0);
        expect_beat('0, 1'b0, 1'b0);
        expect_beat('0, 1'b1, 1'b0);
        send(1'b0, 12'hF9D, '0, 4'd2);
        wait_done();
`else
        // Burst wrapping across the top of the address space.
        write_word(12'hFFE, 16'hA001);
        write_word(12'hFFF, 16'hA002);
        write_word(12'h000, 16'hA003);
        write_word(12'h001, 16'hA004);
        expect_beat(16'hA001, 1'b0, 1'b0);
        expect_beat(16'hA002, 1'b0, 1'b0);
        expect_beat(16'hA003, 1'b0, 1'b0);
        expect_beat(16'hA004, 1'b1, 1'b0);
        send(1'b0, 12'hFFE, '0, 4'd3);
        wait_done();
`endif

        // Reset while the first beat is being fetched (state RD_DATA).
        send(1'b0, 12'h100, '0, 4'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_rsp_last", 32'(rsp_last), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_beat(16'hBEEF, 1'b1, 1'b0);
        send(1'b0, 12'h010, '0, '0);
        wait_done();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
